// File: rtl/branch_pc_unit.sv
// rtl/branch_pc_unit.sv - PC register and conditional-branch sequencer
module branch_pc_unit #(
  parameter int                   PC_WIDTH     = 32,
  parameter int                   OFFSET_WIDTH = 19,
  parameter logic [PC_WIDTH-1:0]  RESET_PC     = '0
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                pc_inc,
  input  logic                pc_load,
  input  logic [PC_WIDTH-1:0] pc_in,
  input  logic                br_start,
  input  logic [31:0]         ir,
  input  logic [PC_WIDTH-1:0] ra_value,
  output logic [1:0]          c2_field,
  output logic [PC_WIDTH-1:0] test_bus,
  output logic                con_in,
  input  logic                con_out,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic                busy,
  output logic                done,
  output logic                taken
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EVAL   = 2'd1,
    SAMPLE = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] offset_q;
  logic [PC_WIDTH-1:0] test_q;
  logic [1:0]          c2_q;
  logic                taken_next_q;
  logic                taken_q;

  logic [PC_WIDTH-1:0] offset_sext;
  logic [PC_WIDTH-1:0] pc_plus_one;
  logic                ir_unused;

  // Only the C2 and displacement fields of the instruction matter here.
  assign ir_unused   = ^ir;
  assign offset_sext = {{(PC_WIDTH-OFFSET_WIDTH){ir[OFFSET_WIDTH-1]}}, ir[OFFSET_WIDTH-1:0]};
  assign pc_plus_one = pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};

  assign pc_out   = pc_q;
  assign c2_field = c2_q;
  assign test_bus = test_q;
  assign taken    = taken_q;

  // Sequencer state register; clear aborts any branch in flight.
  always_ff @(posedge clock) begin
    if (clear) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and strobes; done is masked by clear so an aborted commit never pulses.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    con_in  = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (br_start) state_d = EVAL;
      end
      EVAL: begin
        busy    = 1'b1;
        con_in  = 1'b1;
        state_d = SAMPLE;
      end
      SAMPLE: begin
        busy    = 1'b1;
        state_d = COMMIT;
      end
      COMMIT: begin
        busy    = 1'b1;
        done    = ~clear;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // PC, latched branch operands and branch outcome.
  always_ff @(posedge clock) begin
    if (clear) begin
      pc_q         <= RESET_PC;
      offset_q     <= '0;
      test_q       <= '0;
      c2_q         <= 2'b00;
      taken_next_q <= 1'b0;
      taken_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (br_start) begin
            c2_q     <= ir[20:19];
            offset_q <= offset_sext;
            test_q   <= ra_value;
          end else if (pc_load) begin
            pc_q <= pc_in;
          end else if (pc_inc) begin
            pc_q <= pc_plus_one;
          end
        end
        EVAL: begin
        end
        SAMPLE: begin
          taken_next_q <= con_out;
        end
        COMMIT: begin
          pc_q    <= taken_next_q ? (pc_plus_one + offset_q) : pc_plus_one;
          taken_q <= taken_next_q;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_pc_unit.sv
// tb/tb_branch_pc_unit.sv - self-checking bench for branch_pc_unit
module tb_branch_pc_unit;

  logic        clock = 1'b0;
  logic        clear;
  logic        pc_inc;
  logic        pc_load;
  logic [31:0] pc_in;
  logic        br_start;
  logic [31:0] ir;
  logic [31:0] ra_value;
  logic [1:0]  c2_field;
  logic [31:0] test_bus;
  logic        con_in;
  logic        con_out;
  logic [31:0] pc_out;
  logic        busy;
  logic        done;
  logic        taken;

  int tests = 0;
  int fails = 0;
  logic [31:0] model_pc;

  always #5 clock = ~clock;

  branch_pc_unit #(.PC_WIDTH(32), .OFFSET_WIDTH(19), .RESET_PC(32'h0)) dut (
    .clock(clock), .clear(clear), .pc_inc(pc_inc), .pc_load(pc_load), .pc_in(pc_in),
    .br_start(br_start), .ir(ir), .ra_value(ra_value), .c2_field(c2_field),
    .test_bus(test_bus), .con_in(con_in), .con_out(con_out), .pc_out(pc_out),
    .busy(busy), .done(done), .taken(taken)
  );

  // Condition rule: 00 zero, 01 nonzero, 10 positive, 11 negative.
  function automatic logic cond_of(input logic [1:0] c2, input logic [31:0] v);
    case (c2)
      2'b00:   return v == 32'h0;
      2'b01:   return v != 32'h0;
      2'b10:   return ($signed(v) > 0);
      default: return v[31];
    endcase
  endfunction

  // Condition flip-flop stage: captures the condition on the con_in strobe.
  logic con_ff;
  always @(posedge clock) begin
    if (clear)       con_ff <= 1'b0;
    else if (con_in) con_ff <= cond_of(c2_field, test_bus);
  end
  assign con_out = con_ff;

  function automatic logic [31:0] branch_result(input logic [31:0] pc, input logic [31:0] irv,
                                                input logic [31:0] ra);
    int off;
    off = int'(irv[18:0]);
    if (irv[18]) off = off - 524288;
    if (cond_of(irv[20:19], ra)) return pc + 32'd1 + 32'(off);
    return pc + 32'd1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_pc(input logic [31:0] v);
    pc_load = 1'b1;
    pc_in   = v;
    @(negedge clock);
    pc_load = 1'b0;
    model_pc = v;
    check("set_pc", pc_out, v);
  endtask

  // Drives one branch; noise toggles pc_inc/pc_load/br_start/ir/ra while busy.
  task automatic run_branch(input string name, input logic [31:0] irv, input logic [31:0] ra,
                            input logic exp_taken, input logic [31:0] exp_pc, input logic noise);
    logic [31:0] pc_before;
    pc_before = pc_out;
    br_start = 1'b1; ir = irv; ra_value = ra;
    @(negedge clock);
    br_start = 1'b0;
    check({name, " eval con_in"}, 32'(con_in), 32'd1);
    check({name, " eval busy"}, 32'(busy), 32'd1);
    check({name, " eval c2"}, 32'(c2_field), 32'(irv[20:19]));
    check({name, " eval test_bus"}, test_bus, ra);
    check({name, " eval done"}, 32'(done), 32'd0);
    if (noise) begin
      pc_inc = 1'b1; pc_load = $urandom_range(0, 1); pc_in = $urandom;
      br_start = $urandom_range(0, 1); ir = $urandom; ra_value = $urandom;
    end
    @(negedge clock);
    check({name, " sample con_in"}, 32'(con_in), 32'd0);
    check({name, " sample busy"}, 32'(busy), 32'd1);
    check({name, " sample test_bus"}, test_bus, ra);
    check({name, " sample done"}, 32'(done), 32'd0);
    @(negedge clock);
    check({name, " commit done"}, 32'(done), 32'd1);
    check({name, " commit busy"}, 32'(busy), 32'd1);
    check({name, " commit pc held"}, pc_out, pc_before);
    @(negedge clock);
    pc_inc = 1'b0; pc_load = 1'b0; br_start = 1'b0;
    check({name, " pc"}, pc_out, exp_pc);
    check({name, " taken"}, 32'(taken), 32'(exp_taken));
    check({name, " idle done"}, 32'(done), 32'd0);
    check({name, " idle busy"}, 32'(busy), 32'd0);
    model_pc = exp_pc;
  endtask

  typedef struct {
    string       name;
    logic [31:0] start_pc;
    logic [31:0] irv;
    logic [31:0] ra;
    logic        exp_taken;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{"zero_taken",    32'h10,       32'h0000_0005, 32'h0,         1'b1, 32'h16};
    vecs[1] = '{"zero_not",      32'h10,       32'h0000_0005, 32'h7,         1'b0, 32'h11};
    vecs[2] = '{"nonzero_taken", 32'h10,       32'h0008_0005, 32'h7,         1'b1, 32'h16};
    vecs[3] = '{"neg_back",      32'h20,       32'h001F_FFF8, 32'h8000_0000, 1'b1, 32'h19};
    vecs[4] = '{"pos_not",       32'h20,       32'h0017_FFF8, 32'h8000_0000, 1'b0, 32'h21};
    vecs[5] = '{"wrap_not",      32'hFFFF_FFFF,32'h0000_0005, 32'h1,         1'b0, 32'h0};
    vecs[6] = '{"max_fwd",       32'h100,      32'h000B_FFFF, 32'h1,         1'b1, 32'h0004_0100};
    vecs[7] = '{"max_back",      32'h1000,     32'h001C_0000, 32'hFFFF_FFFF, 1'b1, 32'hFFFC_1001};

    clear = 1'b1; pc_inc = 1'b0; pc_load = 1'b0; pc_in = '0;
    br_start = 1'b0; ir = '0; ra_value = '0;
    @(negedge clock);
    @(negedge clock);
    check("reset pc", pc_out, 32'h0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset taken", 32'(taken), 32'd0);
    check("reset con_in", 32'(con_in), 32'd0);
    check("reset c2", 32'(c2_field), 32'd0);
    check("reset test_bus", test_bus, 32'h0);
    clear = 1'b0;

    pc_inc = 1'b1;
    repeat (3) @(negedge clock);
    pc_inc = 1'b0;
    check("inc x3", pc_out, 32'd3);
    pc_inc = 1'b1; pc_load = 1'b1; pc_in = 32'h100;
    @(negedge clock);
    pc_inc = 1'b0; pc_load = 1'b0;
    check("load beats inc", pc_out, 32'h100);
    @(negedge clock);
    check("idle hold", pc_out, 32'h100);

    for (int i = 0; i < 8; i++) begin
      set_pc(vecs[i].start_pc);
      run_branch(vecs[i].name, vecs[i].irv, vecs[i].ra, vecs[i].exp_taken, vecs[i].exp_pc, i == 5);
    end

    // Clear during SAMPLE after a taken branch.
    set_pc(32'h40);
    run_branch("pre_clear", 32'h0000_0005, 32'h0, 1'b1, 32'h46, 1'b0);
    br_start = 1'b1; ir = 32'h0000_0005; ra_value = 32'h0;
    @(negedge clock);
    br_start = 1'b0;
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    check("clr_sample pc", pc_out, 32'h0);
    check("clr_sample busy", 32'(busy), 32'd0);
    check("clr_sample done", 32'(done), 32'd0);
    check("clr_sample taken", 32'(taken), 32'd0);
    check("clr_sample con_in", 32'(con_in), 32'd0);
    @(negedge clock);
    check("clr_sample no late done", 32'(done), 32'd0);
    check("clr_sample pc stays", pc_out, 32'h0);

    // Clear during COMMIT suppresses the done pulse and the commit.
    set_pc(32'h50);
    br_start = 1'b1; ir = 32'h0000_0005; ra_value = 32'h0;
    @(negedge clock);
    br_start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    clear = 1'b1;
    #1;
    check("clr_commit done", 32'(done), 32'd0);
    @(negedge clock);
    clear = 1'b0;
    check("clr_commit pc", pc_out, 32'h0);
    check("clr_commit busy", 32'(busy), 32'd0);
    model_pc = 32'h0;

    // Randomized mix of idle operations and branches against the model.
    set_pc($urandom);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        logic [31:0] rir, rra, exp;
        rir = $urandom;
        case ($urandom_range(0, 3))
          0:       rra = 32'h0;
          1:       rra = 32'h8000_0000 | $urandom;
          2:       rra = 32'h7FFF_FFFF & $urandom;
          default: rra = $urandom;
        endcase
        exp = branch_result(model_pc, rir, rra);
        run_branch("rand_br", rir, rra, cond_of(rir[20:19], rra), exp, $urandom_range(0, 1));
      end else begin
        logic do_inc, do_load;
        logic [31:0] tgt;
        do_inc = $urandom_range(0, 1); do_load = $urandom_range(0, 1); tgt = $urandom;
        pc_inc = do_inc; pc_load = do_load; pc_in = tgt;
        @(negedge clock);
        pc_inc = 1'b0; pc_load = 1'b0;
        if (do_load)     model_pc = tgt;
        else if (do_inc) model_pc = model_pc + 32'd1;
        check("rand_idle pc", pc_out, model_pc);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/branch_pc_unit.md
Name: branch_pc_unit

Overview:
Program-counter and conditional-branch sequencer for the multi-cycle CPU datapath. Owns the PC register and handles PC increment and jump loads. For branch instructions it drives the condition flip-flop stage: C2 field, register value on its test bus, and the one-cycle CONin strobe. It then samples the resulting CON flag and commits either PC+1 or PC+1+offset.

Parameters:
PC_WIDTH, 32, width of PC and datapath bus
OFFSET_WIDTH, 19, width of the signed branch displacement taken from IR[OFFSET_WIDTH-1:0]
RESET_PC, 0, PC value loaded by clear

Ports:
clock  input  1  system clock, all state updates on rising edge
clear  input  1  synchronous active-high reset
pc_inc  input  1  increment PC by 1 (idle only)
pc_load  input  1  load PC from pc_in (idle only)
pc_in  input  PC_WIDTH  jump target
br_start  input  1  one-cycle pulse starting a branch evaluation
ir  input  32  instruction register; C2 = ir[20:19], offset = ir[OFFSET_WIDTH-1:0]
ra_value  input  PC_WIDTH  value of register Ra under test
c2_field  output  2  condition select to condition FF stage
test_bus  output  PC_WIDTH  value presented to condition FF stage
con_in  output  1  strobe to condition FF stage
con_out  input  1  condition result from condition FF stage
pc_out  output  PC_WIDTH  current PC
busy  output  1  branch sequence in progress
done  output  1  one-cycle pulse when branch PC commit occurs
taken  output  1  result of last branch; held until next commit

Behaviour:
- Clear takes priority over all other inputs, including mid-branch. Reset values: pc_out=RESET_PC, state=IDLE, busy=0, done=0, taken=0, con_in=0, c2_field=0, test_bus=0.
- FSM states: IDLE, EVAL, SAMPLE, COMMIT.
- IDLE:
  - br_start=1: latch C2 = ir[20:19], sign-extended offset and ra_value; go to EVAL. pc_inc and pc_load are ignored in that cycle.
  - Otherwise pc_load=1: PC<=pc_in.
  - Otherwise pc_inc=1: PC<=PC+1.
  - pc_load wins over pc_inc when both are high.
- EVAL (1 cycle):
  - con_in=1.
  - c2_field and test_bus are driven from the latched values.
  - busy=1.
- SAMPLE (1 cycle):
  - con_in=0; c2_field and test_bus held stable.
  - con_out sampled at the end of this cycle into taken_next.
- COMMIT (1 cycle):
  - If taken_next: PC <= PC+1+sext(offset), else PC <= PC+1.
  - taken <= taken_next; done=1 for this cycle.
  - Return to IDLE.
- Latency: br_start at cycle N gives the PC update and done in cycle N+3; busy=1 in cycles N+1..N+3.
- While busy: br_start, pc_inc and pc_load are ignored (not queued).
- Arithmetic: modulo 2^PC_WIDTH; wrap-around is silent (e.g. PC=0xFFFFFFFF, not taken -> 0x00000000).
- Offset: sign-extended from bit OFFSET_WIDTH-1; negative offsets branch backward.
- c2_field/test_bus retain their last latched values in IDLE; they are only guaranteed valid in EVAL and SAMPLE.
- Clear asserted during EVAL/SAMPLE/COMMIT: no PC commit, no done pulse, con_in deasserted the next cycle.

Test Plan:
- Clear then idle, pc_inc pulsed 3 cycles -> pc_out=3; pc_inc+pc_load(pc_in=0x100) same cycle -> pc_out=0x100.
- PC=0x10, ir C2=00 (zero), offset=5, ra_value=0, br_start -> con_in high exactly in cycle N+1; done at N+3; pc_out=0x16; taken=1.
- PC=0x10, C2=00, ra_value=7 -> pc_out=0x11, taken=0; C2=01 same value -> pc_out=0x16, taken=1.
- PC=0x20, C2=11 (negative), ra_value=0x80000000, offset=0x7FFF8 (-8) -> pc_out=0x19; C2=10 with same value -> pc_out=0x21.
- PC=0xFFFFFFFF, not-taken branch -> pc_out=0; pc_inc pulsed during busy -> ignored, PC unchanged apart from commit.
- br_start then clear asserted in SAMPLE cycle -> pc_out=RESET_PC next cycle, no done pulse, busy=0, taken=0.
